// File: rtl/qspi_target_pkg.sv
// Shared definitions for the QSPI flash-target model: opcodes, FSM encoding, line modes.
package qspi_target_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_QUAD_READ = 8'h6B;
  localparam logic [7:0] OP_PP        = 8'h02;
  localparam logic [7:0] OP_QPP       = 8'h32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_WDATA  = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  localparam logic LINE_1 = 1'b0;
  localparam logic LINE_4 = 1'b1;

  typedef struct packed {
    logic ok;
    logic is_read;
    logic lines;
    logic has_dummy;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [7:0] op);
    op_info_t info;
    info = '0;
    info.lines = LINE_1;
    case (op)
      OP_READ: begin
        info.ok      = 1'b1;
        info.is_read = 1'b1;
      end
      OP_FAST_READ: begin
        info.ok        = 1'b1;
        info.is_read   = 1'b1;
        info.has_dummy = 1'b1;
      end
      OP_QUAD_READ: begin
        info.ok        = 1'b1;
        info.is_read   = 1'b1;
        info.has_dummy = 1'b1;
        info.lines     = LINE_4;
      end
      OP_PP: begin
        info.ok = 1'b1;
      end
      OP_QPP: begin
        info.ok    = 1'b1;
        info.lines = LINE_4;
      end
      default: ;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/qspi_target_sync.sv
// Brings sclk, cs_n and IO[3:0] into the qspi_clk domain and derives edge pulses.
module qspi_target_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic [3:0] qio_in,
  output logic       cs_n_s,
  output logic [3:0] qio_s,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       cs_fall,
  output logic       cs_rise
);

  logic [1:0] sclk_ff;
  logic [1:0] cs_ff;
  logic [3:0] qio_ff1;
  logic [3:0] qio_ff2;
  logic       sclk_d;
  logic       cs_d;

  // cs chain clears to "selected" so a frame already in progress at reset
  // produces no fall pulse; only a fresh high->low transition starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_ff <= '0;
      cs_ff   <= '0;
      qio_ff1 <= '0;
      qio_ff2 <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_ff <= {sclk_ff[0], sclk};
      cs_ff   <= {cs_ff[0], cs_n};
      qio_ff1 <= qio_in;
      qio_ff2 <= qio_ff1;
      sclk_d  <= sclk_ff[1];
      cs_d    <= cs_ff[1];
    end
  end

  assign cs_n_s    = cs_ff[1];
  assign qio_s     = qio_ff2;
  assign sclk_rise = sclk_ff[1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[1] & sclk_d;
  assign cs_fall   = ~cs_ff[1] & cs_d;
  assign cs_rise   = cs_ff[1] & ~cs_d;

endmodule

// File: rtl/qspi_target.sv
// SDR QSPI flash target (mode 0): opcode/address/dummy decode, byte-wide memory port.
//  state     | meaning
//  ST_IDLE   | deselected, waiting for a cs_n fall
//  ST_CMD    | shifting opcode on IO0
//  ST_ADDR   | shifting address on IO0
//  ST_DUMMY  | counting dummy clocks, outputs tri-stated
//  ST_RDATA  | driving read data on falls
//  ST_WDATA  | assembling write bytes on rises
//  ST_IGNORE | unknown opcode, idle until deselect
module qspi_target
  import qspi_target_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int FAST_DUMMY = 8,
  parameter int QUAD_DUMMY = 8
) (
  input  logic              qspi_clk,
  input  logic              qspi_rst,
  input  logic              qspi_sclk,
  input  logic              cs_n,
  input  logic [3:0]        qio_in,
  output logic [3:0]        qio_out,
  output logic [3:0]        qio_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic              cmd_valid,
  output logic [7:0]        cmd_opcode,
  output logic              cmd_unsupported,
  output logic              busy
);

  localparam logic [7:0] ADDR_LD = 8'(ADDR_W - 1);
  localparam logic [7:0] FAST_LD = 8'(FAST_DUMMY - 1);
  localparam logic [7:0] QUAD_LD = 8'(QUAD_DUMMY - 1);

  logic       cs_n_s;
  logic [3:0] qio_s;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       cs_fall;
  logic       cs_rise;

  qspi_target_sync u_sync (
    .clk       (qspi_clk),
    .rst       (qspi_rst),
    .sclk      (qspi_sclk),
    .cs_n      (cs_n),
    .qio_in    (qio_in),
    .cs_n_s    (cs_n_s),
    .qio_s     (qio_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  logic [2:0] state;
  logic [7:0] cnt;
  logic [2:0] tx_cnt;
  logic [6:0] opc_sr;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;
  logic [7:0] rd_buf;
  logic       rd_q;
  logic       is_read;
  logic       lines;
  logic       has_dummy;

  logic [7:0]        opcode_now;
  op_info_t          info;
  logic [ADDR_W-1:0] addr_now;
  logic [7:0]        wbyte;
  logic [7:0]        rd_byte;
  logic [2:0]        byte_ld;

  always_comb begin
    opcode_now = {opc_sr, qio_s[0]};
    info       = decode_op(opcode_now);
    addr_now   = {mem_addr[ADDR_W-2:0], qio_s[0]};
    wbyte      = (lines == LINE_4) ? {rx_sr[3:0], qio_s} : {rx_sr, qio_s[0]};
    // Read data arrives the cycle after mem_rd; bypass the buffer so a fall
    // landing in that cycle still sees the fresh byte.
    rd_byte    = rd_q ? mem_rdata : rd_buf;
    byte_ld    = (lines == LINE_4) ? 3'd1 : 3'd7;
  end

  always_ff @(posedge qspi_clk) begin
    if (qspi_rst) begin
      rd_q   <= 1'b0;
      rd_buf <= '0;
    end else begin
      rd_q <= mem_rd;
      if (rd_q) rd_buf <= mem_rdata;
    end
  end

  always_ff @(posedge qspi_clk) begin
    if (qspi_rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      tx_cnt          <= '0;
      opc_sr          <= '0;
      rx_sr           <= '0;
      tx_sr           <= '0;
      is_read         <= 1'b0;
      lines           <= LINE_1;
      has_dummy       <= 1'b0;
      qio_out         <= '0;
      qio_oe          <= '0;
      mem_addr        <= '0;
      mem_rd          <= 1'b0;
      mem_wr          <= 1'b0;
      mem_wdata       <= '0;
      cmd_valid       <= 1'b0;
      cmd_opcode      <= '0;
      cmd_unsupported <= 1'b0;
      busy            <= 1'b0;
    end else begin
      cmd_valid       <= 1'b0;
      cmd_unsupported <= 1'b0;
      mem_rd          <= 1'b0;
      mem_wr          <= 1'b0;
      if (mem_wr) mem_addr <= mem_addr + 1'b1;

      if (cs_n_s) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        tx_cnt  <= '0;
        qio_out <= '0;
        qio_oe  <= '0;
        busy    <= 1'b0;
        if (cs_rise) rx_sr <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state <= ST_CMD;
              cnt   <= 8'd7;
              busy  <= 1'b1;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              opc_sr <= opcode_now[6:0];
              if (cnt == 8'd0) begin
                cmd_valid  <= 1'b1;
                cmd_opcode <= opcode_now;
                is_read    <= info.is_read;
                lines      <= info.lines;
                has_dummy  <= info.has_dummy;
                if (info.ok) begin
                  state <= ST_ADDR;
                  cnt   <= ADDR_LD;
                end else begin
                  state           <= ST_IGNORE;
                  cmd_unsupported <= 1'b1;
                end
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise) begin
              mem_addr <= addr_now;
              if (cnt == 8'd0) begin
                if (is_read) begin
                  mem_rd <= 1'b1;
                  tx_cnt <= '0;
                  if (has_dummy) begin
                    state <= ST_DUMMY;
                    cnt   <= (lines == LINE_4) ? QUAD_LD : FAST_LD;
                  end else begin
                    state <= ST_RDATA;
                  end
                end else begin
                  state <= ST_WDATA;
                  cnt   <= {5'd0, byte_ld};
                end
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
          end
          ST_DUMMY: begin
            if (sclk_rise) begin
              if (cnt == 8'd0) state <= ST_RDATA;
              else             cnt   <= cnt - 8'd1;
            end
          end
          ST_RDATA: begin
            if (sclk_fall) begin
              qio_oe <= (lines == LINE_4) ? 4'b1111 : 4'b0010;
              if (tx_cnt == 3'd0) begin
                // first bit of a new byte leaves now: prefetch the following byte
                tx_cnt   <= byte_ld;
                mem_addr <= mem_addr + 1'b1;
                mem_rd   <= 1'b1;
                if (lines == LINE_4) begin
                  qio_out <= rd_byte[7:4];
                  tx_sr   <= {rd_byte[3:0], 4'b0000};
                end else begin
                  qio_out <= {2'b00, rd_byte[7], 1'b0};
                  tx_sr   <= {rd_byte[6:0], 1'b0};
                end
              end else begin
                tx_cnt <= tx_cnt - 3'd1;
                if (lines == LINE_4) begin
                  qio_out <= tx_sr[7:4];
                  tx_sr   <= {tx_sr[3:0], 4'b0000};
                end else begin
                  qio_out <= {2'b00, tx_sr[7], 1'b0};
                  tx_sr   <= {tx_sr[6:0], 1'b0};
                end
              end
            end
          end
          ST_WDATA: begin
            if (sclk_rise) begin
              rx_sr <= wbyte[6:0];
              if (cnt == 8'd0) begin
                mem_wr    <= 1'b1;
                mem_wdata <= wbyte;
                cnt       <= {5'd0, byte_ld};
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_target.sv
// Directed bench for qspi_target: drives mode-0 QSPI frames and checks the memory port.
module tb_qspi_target;

  logic        qspi_clk = 1'b0;
  logic        qspi_rst;
  logic        qspi_sclk;
  logic        cs_n;
  logic [3:0]  qio_in;
  logic [3:0]  qio_out;
  logic [3:0]  qio_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic        cmd_unsupported;
  logic        busy;

  qspi_target dut (
    .qspi_clk        (qspi_clk),
    .qspi_rst        (qspi_rst),
    .qspi_sclk       (qspi_sclk),
    .cs_n            (cs_n),
    .qio_in          (qio_in),
    .qio_out         (qio_out),
    .qio_oe          (qio_oe),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_rdata       (mem_rdata),
    .mem_wr          (mem_wr),
    .mem_wdata       (mem_wdata),
    .cmd_valid       (cmd_valid),
    .cmd_opcode      (cmd_opcode),
    .cmd_unsupported (cmd_unsupported),
    .busy            (busy)
  );

  always #5 qspi_clk = ~qspi_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [256];
  logic [23:0] wlog_a [8];
  logic [7:0]  wlog_d [8];
  int wcount  = 0;
  int rd_cnt  = 0;
  int cv_cnt  = 0;
  int cu_cnt  = 0;
  int overlap = 0;

  always @(posedge qspi_clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (mem_rd && mem_wr) overlap <= overlap + 1;
    if (cmd_valid) cv_cnt <= cv_cnt + 1;
    if (cmd_unsupported) cu_cnt <= cu_cnt + 1;
    if (mem_wr) begin
      if (wcount < 8) begin
        wlog_a[wcount] <= mem_addr;
        wlog_d[wcount] <= mem_wdata;
      end
      wcount <= wcount + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sclk_cycle(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] doe);
    qio_in = din;
    repeat (4) @(negedge qspi_clk);
    dout = qio_out;
    doe  = qio_oe;
    qspi_sclk = 1'b1;
    repeat (4) @(negedge qspi_clk);
    qspi_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    logic [3:0] d, e;
    for (int i = n - 1; i >= 0; i--) sclk_cycle({3'b000, val[i]}, d, e);
  endtask

  task automatic send_nibbles(input logic [31:0] val, input int n);
    logic [3:0] d, e;
    for (int i = n - 1; i >= 0; i--) sclk_cycle(val[i*4 +: 4], d, e);
  endtask

  // collect n cycles; oe_ok stays 1 only if every sample matched oe_exp
  task automatic read_cycles(input int n, input logic quad, input logic [3:0] oe_exp,
                             output logic [31:0] data, output logic oe_ok);
    logic [3:0] d, e;
    data  = '0;
    oe_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      sclk_cycle(4'h0, d, e);
      data = quad ? {data[27:0], d} : {data[30:0], d[1]};
      if (e !== oe_exp) oe_ok = 1'b0;
    end
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    repeat (4) @(negedge qspi_clk);
  endtask

  task automatic frame_end();
    repeat (2) @(negedge qspi_clk);
    cs_n = 1'b1;
    repeat (6) @(negedge qspi_clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] data;
    logic        ok;
    int          rd0, cv0, cu0, w0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    qspi_rst  = 1'b1;
    qspi_sclk = 1'b0;
    cs_n      = 1'b1;
    qio_in    = 4'h0;
    repeat (4) @(negedge qspi_clk);

    chk("rst_qio_out", {28'd0, qio_out}, 32'd0);
    chk("rst_qio_oe", {28'd0, qio_oe}, 32'd0);
    chk("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
    chk("rst_strobes", {28'd0, mem_rd, mem_wr, cmd_valid, cmd_unsupported}, 32'd0);
    chk("rst_opcode_wdata_busy", {15'd0, cmd_opcode, mem_wdata, busy}, 32'd0);
    qspi_rst = 1'b0;
    repeat (6) @(negedge qspi_clk);

    // 0x03 READ @0x000010
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h12] = 8'hFF;
    cv0 = cv_cnt;
    frame_start();
    send_bits(32'h03, 8);
    chk("read_opcode", {24'd0, cmd_opcode}, 32'h03);
    chk("read_busy", {31'd0, busy}, 32'd1);
    send_bits(32'h000010, 24);
    read_cycles(24, 1'b0, 4'b0010, data, ok);
    chk("read_data", data, 32'h00A53CFF);
    chk("read_oe", {31'd0, ok}, 32'd1);
    frame_end();
    chk("read_cmd_valid_cnt", cv_cnt - cv0, 32'd1);
    chk("read_end_oe_busy", {27'd0, qio_oe, busy}, 32'd0);

    // 0x6B QUAD_READ @0x0000FE with 8 dummy clocks
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    frame_start();
    send_bits(32'h6B, 8);
    send_bits(32'h0000FE, 24);
    read_cycles(8, 1'b1, 4'b0000, data, ok);
    chk("quad_dummy_oe", {31'd0, ok}, 32'd1);
    read_cycles(6, 1'b1, 4'b1111, data, ok);
    chk("quad_data", data, 32'h00112233);
    chk("quad_oe", {31'd0, ok}, 32'd1);
    frame_end();

    // 0x32 QPP @0xFFFFFF, DE AD wraps to 0x000000
    w0 = wcount;
    frame_start();
    send_bits(32'h32, 8);
    send_bits(32'hFFFFFF, 24);
    send_nibbles(32'hDEAD, 4);
    frame_end();
    chk("qpp_wr_count", wcount - w0, 32'd2);
    chk("qpp_wr0", {wlog_a[w0], wlog_d[w0]}, 32'hFFFFFFDE);
    chk("qpp_wr1", {wlog_a[w0+1], wlog_d[w0+1]}, 32'h000000AD);
    chk("qpp_addr_wrapped", {8'd0, mem_addr}, 32'h000001);

    // 0x02 PP @0x000100, one byte plus a dropped half byte
    w0 = wcount;
    frame_start();
    send_bits(32'h02, 8);
    send_bits(32'h000100, 24);
    send_bits(32'h5A, 8);
    send_bits(32'hB, 4);
    frame_end();
    chk("pp_wr_count", wcount - w0, 32'd1);
    chk("pp_wr0", {wlog_a[w0], wlog_d[w0]}, 32'h0001005A);

    // unsupported opcode 0x9F
    rd0 = rd_cnt; cv0 = cv_cnt; cu0 = cu_cnt; w0 = wcount;
    frame_start();
    send_bits(32'h9F, 8);
    read_cycles(16, 1'b0, 4'b0000, data, ok);
    frame_end();
    chk("unsup_opcode", {24'd0, cmd_opcode}, 32'h9F);
    chk("unsup_pulses", {cv_cnt - cv0, cu_cnt - cu0}, {32'd1, 32'd1});
    chk("unsup_oe", {31'd0, ok}, 32'd1);
    chk("unsup_no_strobes", {rd_cnt - rd0, wcount - w0}, 64'd0);

    // 0x0B FAST_READ, reset mid-data, then a clean READ
    frame_start();
    send_bits(32'h0B, 8);
    send_bits(32'h000010, 24);
    read_cycles(8, 1'b0, 4'b0000, data, ok);
    read_cycles(8, 1'b0, 4'b0010, data, ok);
    chk("fast_data", data, 32'h000000A5);
    qspi_rst = 1'b1;
    repeat (2) @(negedge qspi_clk);
    chk("midrst_outputs", {12'd0, qio_out, qio_oe, mem_rd, mem_wr, cmd_valid, busy, mem_wdata}, 32'd0);
    chk("midrst_addr_opcode", {mem_addr, cmd_opcode}, 32'd0);
    qspi_rst = 1'b0;
    rd0 = rd_cnt;
    read_cycles(8, 1'b0, 4'b0000, data, ok);
    chk("midrst_ignored_oe", {31'd0, ok}, 32'd1);
    chk("midrst_ignored_busy_rd", {busy, 31'(rd_cnt - rd0)}, 32'd0);
    frame_end();
    frame_start();
    send_bits(32'h03, 8);
    send_bits(32'h000011, 24);
    read_cycles(16, 1'b0, 4'b0010, data, ok);
    chk("postrst_read", data, 32'h00003CFF);
    chk("postrst_oe", {31'd0, ok}, 32'd1);
    frame_end();

    chk("rd_wr_overlap", overlap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
